aes_key_sched_buf: RTL and testbench

Multi-slot AES key schedule engine for the crypto datapath. It accepts a cipher key of 128, 192 or 256 bits and expands it one 32-bit word per cycle. The full round-key set is stored in one of `NUM_SLOTS` key slots. The cipher cores read any round key of any completed slot in either order, so encrypt and decrypt rounds share one schedule and several DMA channels can keep distinct keys resident.

---
 rtl/aes_key_sched_buf_pkg.sv | 52 +++++
 rtl/aes_key_sched_buf_if.sv | 31 +++
 rtl/aes_key_sched_buf_word_gen.sv | 39 +++
 rtl/aes_sbox.sv | 22 ++
 rtl/aes_key_sched_buf.sv | 151 +++++++++++++++
 tb/tb_aes_key_sched_buf.sv | 314 +++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/aes_key_sched_buf_pkg.sv
// Shared AES key-schedule definitions: key-length codes, per-length Nk/Nr/T, GF(2^8) helpers.
// Pure package, no state; latency and backpressure belong to the modules that import it.
package aes_kep_pkg;

    localparam logic [1:0] KLEN_128 = 2'b00;
    localparam logic [1:0] KLEN_192 = 2'b01;
    localparam logic [1:0] KLEN_256 = 2'b10;
    localparam logic [1:0] KLEN_BAD = 2'b11;

    localparam int ROWS = 15;

    function automatic logic [3:0] nk_of(input logic [1:0] kl);
        case (kl)
            KLEN_192: return 4'd6;
            KLEN_256: return 4'd8;
            default:  return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        case (kl)
            KLEN_192: return 4'd12;
            KLEN_256: return 4'd14;
            default:  return 4'd10;
        endcase
    endfunction

    function automatic logic [5:0] tw_of(input logic [1:0] kl);
        case (kl)
            KLEN_192: return 6'd52;
            KLEN_256: return 6'd60;
            default:  return 6'd44;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_key_sched_buf_if.sv
// Load and round-key read bundle of the key schedule buffer.
// Loads use valid/ready; reads are fire-and-forget with a one-cycle registered response.
interface aes_key_sched_buf_if #(
    parameter int NUM_SLOTS = 4,
    parameter int SLOT_W    = $clog2(NUM_SLOTS)
);
    logic                 key_valid;
    logic                 key_ready;
    logic [255:0]         key;
    logic [1:0]           key_len;
    logic [SLOT_W-1:0]    key_slot;
    logic                 exp_done;
    logic                 load_err;
    logic [NUM_SLOTS-1:0] slot_valid;
    logic                 rk_req;
    logic [SLOT_W-1:0]    rk_slot;
    logic [3:0]           rk_round;
    logic [127:0]         rk_data;
    logic                 rk_valid;
    logic                 rk_err;

    modport master (
        output key_valid, key, key_len, key_slot, rk_req, rk_slot, rk_round,
        input  key_ready, exp_done, load_err, slot_valid, rk_data, rk_valid, rk_err
    );

    modport slave (
        input  key_valid, key, key_len, key_slot, rk_req, rk_slot, rk_round,
        output key_ready, exp_done, load_err, slot_valid, rk_data, rk_valid, rk_err
    );
endinterface

// File: rtl/aes_key_sched_buf_word_gen.sv
// Next schedule word w[i] from the sliding window (win[0] = w[i-1]), j = i mod Nk and rcon.
// Combinational, no handshake; the caller decides when the result is written.
module aes_kep_word_gen
    import aes_kep_pkg::*;
(
    input  logic [7:0][31:0] win,
    input  logic [2:0]       j,
    input  logic [3:0]       nk,
    input  logic [7:0]       rcon,
    output logic [31:0]      word
);
    logic [31:0] prev;
    logic [31:0] old;
    logic [31:0] sb_in;
    logic [31:0] sb_out;
    logic [31:0] temp;
    logic [2:0]  old_idx;

    assign prev    = win[0];
    assign old_idx = 3'(nk - 4'd1);
    assign old     = win[old_idx];
    // RotWord is only a byte mux, so both SubWord forms share the same four S-boxes
    assign sb_in   = (j == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (.a(sb_in[8*b +: 8]), .y(sb_out[8*b +: 8]));
    end

    always_comb begin
        temp = prev;
        if (j == 3'd0) begin
            temp = sb_out ^ {rcon, 24'h000000};
        end else if (nk == 4'd8 && j == 3'd4) begin
            temp = sb_out;
        end
    end

    assign word = old ^ temp;
endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box: multiplicative inverse (a^254) followed by the affine map.
// Purely combinational, no handshake.
module aes_sbox
    import aes_kep_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);
    logic [7:0] p;
    logic [7:0] inv;

    always_comb begin
        p = a;
        // square-and-multiply builds a^127; one more squaring gives a^254 = a^-1 (0 stays 0)
        for (int k = 0; k < 6; k++) begin
            p = gf_mul(gf_mul(p, p), a);
        end
        inv = gf_mul(p, p);
        y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
            {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

// File: rtl/aes_key_sched_buf.sv
// Multi-slot AES key expansion (one word/cycle, T-Nk+1 cycles accept to exp_done) with round-key reads.
// key_ready is low while expanding; reads have one-cycle latency and never stall.
module aes_key_sched_buf
    import aes_kep_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_key_sched_buf_if.slave   bus
);
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_EXPAND = 1'b1;

    logic [0:0]                 state;
    logic [SLOT_W-1:0]          cur_slot;
    logic [1:0]                 cur_len;
    logic [5:0]                 widx;
    logic [2:0]                 j;
    logic [7:0]                 rcon;
    logic [7:0][31:0]           win;
    logic [NUM_SLOTS-1:0]       slot_valid;
    logic [NUM_SLOTS-1:0][1:0]  slot_len;
    logic [127:0]               mem [NUM_SLOTS][ROWS];

    logic             key_ready;
    logic             accept;
    logic             load;
    logic [3:0]       nk_new;
    logic [3:0]       nk_cur;
    logic             expand_wr;
    logic             finish;
    logic [31:0]      new_word;
    logic [7:0][31:0] key_words;
    logic [7:0][31:0] win_init;
    logic             exp_done;
    logic             load_err;
    logic             rd_hit;
    logic [3:0]       rd_row;
    logic [127:0]     rk_data;
    logic             rk_valid;
    logic             rk_err;

    assign key_ready = (state == ST_IDLE);
    assign accept    = bus.key_valid && key_ready;
    assign load      = accept && (bus.key_len != KLEN_BAD);
    assign nk_new    = nk_of(bus.key_len);
    assign nk_cur    = nk_of(cur_len);
    assign expand_wr = (state == ST_EXPAND) && (widx != tw_of(cur_len));
    assign finish    = (state == ST_EXPAND) && (widx == tw_of(cur_len));

    always_comb begin
        key_words = '0;
        win_init  = '0;
        for (int m = 0; m < 8; m++) begin
            key_words[3'(m)] = bus.key[255-32*m -: 32];
        end
        // newest key word sits at win[0] so the window looks as if it had been shifted in
        for (int k = 0; k < 8; k++) begin
            if (4'(k) < nk_new) win_init[3'(k)] = key_words[3'(nk_new - 4'd1 - 4'(k))];
        end
    end

    aes_kep_word_gen u_word_gen (
        .win  (win),
        .j    (j),
        .nk   (nk_cur),
        .rcon (rcon),
        .word (new_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cur_slot   <= '0;
            cur_len    <= KLEN_128;
            widx       <= '0;
            j          <= '0;
            rcon       <= 8'h01;
            win        <= '0;
            slot_valid <= '0;
            slot_len   <= '0;
            exp_done   <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            exp_done <= 1'b0;
            load_err <= accept && (bus.key_len == KLEN_BAD);
            if (load) begin
                state                <= ST_EXPAND;
                cur_slot             <= bus.key_slot;
                cur_len              <= bus.key_len;
                slot_len[bus.key_slot]   <= bus.key_len;
                slot_valid[bus.key_slot] <= 1'b0;
                widx                 <= {2'b00, nk_new};
                j                    <= 3'd0;
                rcon                 <= 8'h01;
                win                  <= win_init;
            end else if (expand_wr) begin
                win  <= {win[6:0], new_word};
                widx <= widx + 6'd1;
                j    <= (j == 3'(nk_cur - 4'd1)) ? 3'd0 : j + 3'd1;
                if (j == 3'd0) rcon <= xtime(rcon);
            end else if (finish) begin
                state                <= ST_IDLE;
                exp_done             <= 1'b1;
                slot_valid[cur_slot] <= 1'b1;
            end
        end
    end

    // storage is deliberately not reset; slot_valid alone guards stale contents
    always_ff @(posedge clk) begin
        if (load) begin
            for (int m = 0; m < 8; m++) begin
                if (4'(m) < nk_new) mem[bus.key_slot][4'(m/4)][127-32*(m%4) -: 32] <= key_words[3'(m)];
            end
        end
        if (expand_wr) begin
            for (int l = 0; l < 4; l++) begin
                if (widx[1:0] == 2'(l)) mem[cur_slot][widx[5:2]][127-32*l -: 32] <= new_word;
            end
        end
    end

    // a slot being accepted this very cycle is already treated as invalid
    assign rd_hit = slot_valid[bus.rk_slot] &&
                    !(load && (bus.key_slot == bus.rk_slot)) &&
                    (bus.rk_round <= nr_of(slot_len[bus.rk_slot]));
    assign rd_row = (bus.rk_round > 4'd14) ? 4'd0 : bus.rk_round;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk_data  <= '0;
            rk_valid <= 1'b0;
            rk_err   <= 1'b0;
        end else begin
            rk_valid <= bus.rk_req && rd_hit;
            rk_err   <= bus.rk_req && !rd_hit;
            if (bus.rk_req) rk_data <= rd_hit ? mem[bus.rk_slot][rd_row] : 128'h0;
        end
    end

    assign bus.key_ready  = key_ready;
    assign bus.exp_done   = exp_done;
    assign bus.load_err   = load_err;
    assign bus.slot_valid = slot_valid;
    assign bus.rk_data    = rk_data;
    assign bus.rk_valid   = rk_valid;
    assign bus.rk_err     = rk_err;
endmodule

// File: tb/tb_aes_key_sched_buf.sv
// Bench for aes_key_sched_buf: randomized loads/reads against a FIPS-197 style reference model.
module tb_aes_key_sched_buf;
    localparam int NS = 4;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_key_sched_buf_if #(.NUM_SLOTS(NS)) bus ();
    aes_key_sched_buf #(.NUM_SLOTS(NS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        int           cyc;
        logic         vld;
        logic         err;
        logic [127:0] dat;
        logic [127:0] msk;
    } rd_exp_t;

    rd_exp_t rd_q[$];
    int      done_q[$];
    int      lerr_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  sbox [256];
    logic [31:0] mkey [NS][60];
    bit          mv [NS];
    int          mlen [NS];
    bit          busy = 1'b0;
    int          busy_slot = 0;
    int          done_at = 0;
    bit          exp_ready = 1'b1;

    localparam logic [127:0] ALL = {128{1'b1}};

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s cyc=%0d", nm, cyc);
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // table built by walking generator 3 and its inverse, independent of any inversion circuit
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        for (int n = 0; n < 255; n++) begin
            p = p ^ (p << 1) ^ ((p & 8'h80) != 0 ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if ((q & 8'h80) != 0) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox[p] = x ^ 8'h63;
        end
        sbox[0] = 8'h63;
    endtask

    function automatic logic [31:0] subw(input logic [31:0] v);
        return {sbox[v[31:24]], sbox[v[23:16]], sbox[v[15:8]], sbox[v[7:0]]};
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        int v;
        v = int'(b) * 2;
        if (v > 255) v = v ^ 'h11b;
        return v[7:0];
    endfunction

    task automatic model_expand(input int s, input logic [255:0] k, input int nk);
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < nk; i++) mkey[s][i] = k[255-32*i -: 32];
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            t = mkey[s][i-1];
            if (i % nk == 0) begin
                rc = 8'h01;
                for (int q = 1; q < i / nk; q++) rc = xt(rc);
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            end else if (nk == 8 && i % nk == 4) begin
                t = subw(t);
            end
            mkey[s][i] = mkey[s][i-nk] ^ t;
        end
    endtask

    // one clock: drive inputs, queue the expected responses, then advance the model past the edge
    task automatic drive(input bit do_load, input logic [255:0] k, input logic [1:0] kl, input int ks,
                         input bit do_rd, input int rs, input int rr,
                         input bit lit_chk = 1'b0, input logic [127:0] lit = '0, input logic [127:0] lmsk = '0);
        bit      acc;
        bit      legal;
        bit      ok;
        int      nk;
        rd_exp_t e;
        bus.key_valid = do_load;
        bus.key       = k;
        bus.key_len   = kl;
        bus.key_slot  = ks[SW-1:0];
        bus.rk_req    = do_rd;
        bus.rk_slot   = rs[SW-1:0];
        bus.rk_round  = rr[3:0];
        acc   = do_load && exp_ready;
        legal = acc && (kl != 2'b11);
        if (acc && kl == 2'b11) lerr_q.push_back(cyc + 1);
        if (do_rd) begin
            ok    = mv[rs] && !(legal && ks == rs) && (rr <= mlen[rs] + 6);
            e.cyc = cyc + 1;
            e.vld = ok;
            e.err = !ok;
            e.msk = ALL;
            e.dat = '0;
            if (ok) begin
                e.dat = {mkey[rs][4*rr], mkey[rs][4*rr+1], mkey[rs][4*rr+2], mkey[rs][4*rr+3]};
                if (lit_chk) begin
                    e.dat = lit;
                    e.msk = lmsk;
                end
            end
            rd_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (legal) begin
            nk = 4 + 2 * int'(kl);
            model_expand(ks, k, nk);
            mlen[ks]  = nk;
            mv[ks]    = 1'b0;
            busy      = 1'b1;
            busy_slot = ks;
            done_at   = cyc + (4 * (nk + 7) - nk) + 1;
            done_q.push_back(done_at);
            exp_ready = 1'b0;
        end
        if (busy && cyc == done_at) begin
            mv[busy_slot] = 1'b1;
            busy          = 1'b0;
            exp_ready     = 1'b1;
        end
    endtask

    task automatic rd(input int rs, input int rr);
        drive(1'b0, '0, 2'b00, 0, 1'b1, rs, rr);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (busy && n < 200) begin
            drive(($urandom_range(0, 7) == 0), {8{$urandom}}, 2'($urandom_range(0, 3)), $urandom_range(0, NS-1),
                  1'b1, $urandom_range(0, NS-1), $urandom_range(0, 15));
            n++;
        end
        if (busy) fail("expand_timeout");
    endtask

    function automatic logic [255:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    always @(negedge clk) begin
        rd_exp_t         e;
        logic [NS-1:0]   v;
        for (int s = 0; s < NS; s++) v[s] = mv[s];
        chk("key_ready", 128'(bus.key_ready), 128'(exp_ready));
        chk("slot_valid", 128'(bus.slot_valid), 128'(v));
        if (bus.exp_done) begin
            if (done_q.size() == 0) fail("exp_done_unexpected");
            else chk("exp_done_cycle", 128'(cyc), 128'(done_q.pop_front()));
        end else if (done_q.size() != 0 && done_q[0] <= cyc) begin
            fail("exp_done_missing");
            void'(done_q.pop_front());
        end
        if (bus.load_err) begin
            if (lerr_q.size() == 0) fail("load_err_unexpected");
            else chk("load_err_cycle", 128'(cyc), 128'(lerr_q.pop_front()));
        end else if (lerr_q.size() != 0 && lerr_q[0] <= cyc) begin
            fail("load_err_missing");
            void'(lerr_q.pop_front());
        end
        if (bus.rk_valid || bus.rk_err) begin
            if (rd_q.size() == 0) begin
                fail("rk_unexpected");
            end else begin
                e = rd_q.pop_front();
                chk("rk_cycle", 128'(cyc), 128'(e.cyc));
                chk("rk_valid", 128'(bus.rk_valid), 128'(e.vld));
                chk("rk_err", 128'(bus.rk_err), 128'(e.err));
                chk("rk_data", bus.rk_data & e.msk, e.dat & e.msk);
            end
        end else if (rd_q.size() != 0 && rd_q[0].cyc <= cyc) begin
            fail("rk_missing");
            void'(rd_q.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] k;
        build_sbox();
        for (int s = 0; s < NS; s++) begin
            mv[s]   = 1'b0;
            mlen[s] = 4;
        end
        bus.key_valid = 1'b0;
        bus.key       = '0;
        bus.key_len   = 2'b00;
        bus.key_slot  = '0;
        bus.rk_req    = 1'b0;
        bus.rk_slot   = '0;
        bus.rk_round  = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        chk("rst_key_ready", 128'(bus.key_ready), 128'(1));
        chk("rst_exp_done", 128'(bus.exp_done), 128'(0));
        chk("rst_load_err", 128'(bus.load_err), 128'(0));
        chk("rst_slot_valid", 128'(bus.slot_valid), 128'(0));
        chk("rst_rk_valid", 128'(bus.rk_valid), 128'(0));
        chk("rst_rk_err", 128'(bus.rk_err), 128'(0));
        chk("rst_rk_data", bus.rk_data, 128'h0);

        // FIPS-197 128-bit key into slot 0
        drive(1'b1, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 2'b00, 0, 1'b0, 0, 0);
        wait_done();
        drive(1'b0, '0, 2'b00, 0, 1'b1, 0, 10, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, ALL);
        for (int r = 0; r <= 11; r++) rd(0, r);

        // 192-bit key into slot 1, read back in reverse order
        drive(1'b1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 2'b01, 1, 1'b1, 0, 3);
        wait_done();
        drive(1'b0, '0, 2'b00, 0, 1'b1, 1, 12, 1'b1, {96'h0, 32'h01002202}, {96'h0, 32'hffffffff});
        for (int r = 12; r >= 0; r--) rd(1, r);
        rd(1, 13);

        // 256-bit key into slot 3
        drive(1'b1, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 2'b10, 3, 1'b0, 0, 0);
        wait_done();
        drive(1'b0, '0, 2'b00, 0, 1'b1, 3, 14, 1'b1, {96'h0, 32'h706c631e}, {96'h0, 32'hffffffff});
        rd(3, 15);
        rd(3, 0);

        // illegal length into a valid and an empty slot
        drive(1'b1, rand_key(), 2'b11, 0, 1'b1, 0, 5);
        drive(1'b1, rand_key(), 2'b11, 2, 1'b1, 2, 0);
        rd(0, 10);

        // reload slot 0 while alternating reads of slot 0 and slot 1
        drive(1'b1, rand_key(), 2'b00, 0, 1'b1, 0, $urandom_range(0, 10));
        for (int n = 0; n < 200 && busy; n++) begin
            drive(1'b0, '0, 2'b00, 0, 1'b1, n % 2, $urandom_range(0, 10));
        end
        for (int r = 0; r <= 10; r++) rd(0, r);

        // abort an expansion with reset at expansion cycle 20
        k = rand_key();
        drive(1'b1, k, 2'b10, 2, 1'b0, 0, 0);
        repeat (19) drive(1'b0, '0, 2'b00, 0, 1'b0, 0, 0);
        rst_n = 1'b0;
        for (int s = 0; s < NS; s++) mv[s] = 1'b0;
        busy      = 1'b0;
        exp_ready = 1'b1;
        done_q.delete();
        #1;
        chk("abort_slot_valid", 128'(bus.slot_valid), 128'(0));
        chk("abort_key_ready", 128'(bus.key_ready), 128'(1));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, '0, 2'b00, 0, 1'b0, 0, 0);
        rd(0, 0);
        drive(1'b1, k, 2'b10, 2, 1'b0, 0, 0);
        wait_done();
        for (int r = 0; r <= 14; r++) rd(2, r);

        // random back-to-back loads with mixed reads
        for (int n = 0; n < 16; n++) begin
            drive(1'b1, rand_key(), ($urandom_range(0, 5) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
                  $urandom_range(0, NS-1), 1'b1, $urandom_range(0, NS-1), $urandom_range(0, 15));
            wait_done();
            repeat ($urandom_range(0, 3)) rd($urandom_range(0, NS-1), $urandom_range(0, 15));
        end

        repeat (3) drive(1'b0, '0, 2'b00, 0, 1'b0, 0, 0);
        chk("rd_q_drained", 128'(rd_q.size()), 128'(0));
        chk("done_q_drained", 128'(done_q.size()), 128'(0));
        chk("lerr_q_drained", 128'(lerr_q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
